// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: requester
// count, index width, FSM state encoding and the hold counter width.
package rr_arbiter8_pkg;

  localparam int NUM_REQ    = 8;
  localparam int REQ_IDX_W  = 3;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  typedef logic [NUM_REQ-1:0]    req_vec_t;
  typedef logic [REQ_IDX_W-1:0]  req_idx_t;
  typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

endpackage

// File: rtl/rr_arbiter8_decoder.sv
// 3-to-8 one-hot decoder. Purely combinational; the arbiter feeds it from
// the registered grant index so the grant vector has no path from req.
module decoder
  import rr_arbiter8_pkg::*;
(
  input  logic [REQ_IDX_W-1:0] sel_i,
  output logic [NUM_REQ-1:0]   onehot_o
);

  // One output bit per requester, high when the select matches its index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
      assign onehot_o[gi] = (sel_i == REQ_IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter. A winner holds the resource until it
// drops its request or MAX_HOLD cycles elapse; then one GAP cycle and one
// IDLE cycle pass before the next arbitration, which starts scanning just
// above the previous winner. MAX_HOLD must lie in 2..255 so the terminal
// count fits the 8-bit hold counter.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [REQ_IDX_W-1:0] grant_id,
  output logic                 grant_valid,
  output logic                 expired
);

  // Last hold count value before a forced release.
  localparam hold_cnt_t HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  arb_state_e state_q,    state_d;
  req_idx_t   ptr_q,      ptr_d;
  req_idx_t   grant_id_q, grant_id_d;
  hold_cnt_t  hold_cnt_q, hold_cnt_d;
  logic       expired_q,  expired_d;

  logic       pick_found;
  req_idx_t   pick_idx;
  req_vec_t   dec_onehot;

  // Priority scan starting at ptr with wrap: rotate the request vector so
  // ptr lands at bit 0, take the lowest set bit, then add ptr back.
  function automatic logic [REQ_IDX_W:0] rr_pick(input req_vec_t r, input req_idx_t p);
    logic [2*NUM_REQ-1:0] dbl;
    req_vec_t             rot;
    req_idx_t             idx;
    req_idx_t             winner;
    logic                 found;
    dbl   = {r, r} >> p;
    rot   = dbl[NUM_REQ-1:0];
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx   = REQ_IDX_W'(i);
        found = 1'b1;
      end
    end
    winner = idx + p;
    return {found, winner};
  endfunction

  // Candidate winner for the current request vector and pointer.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, ptr_q);
  end

  // State register: every piece of arbiter state, cleared by reset_n.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
      expired_q  <= expired_d;
    end
  end

  // Next-state logic: arbitration in IDLE, release/timeout in GRANT,
  // pointer advance in GAP. expired defaults low so it lasts one cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          hold_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Only the holder's request bit matters here; release wins over
        // the timeout when both happen on the same cycle.
        if (!req[grant_id_q]) begin
          state_d = ARB_GAP;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = ARB_GAP;
          expired_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ARB_GAP: begin
        ptr_d   = grant_id_q + 1'b1;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // One-hot grant for the registered winner.
  decoder u_decoder (
    .sel_i    (grant_id_q),
    .onehot_o (dec_onehot)
  );

  // Outputs: all taken from registered state, the grant masked by validity.
  always_comb begin
    grant_valid = (state_q == ARB_GRANT);
    grant_id    = grant_id_q;
    expired     = expired_q;
    grant       = dec_onehot & {NUM_REQ{grant_valid}};
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios with constant
// expectations plus a randomized run against a cycle-level reference model.
module tb_rr_arbiter8;

  localparam int TB_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       expired;

  int errors = 0;
  int checks = 0;

  // Reference model: current holder (-1 none), granted cycles so far,
  // whether the turnaround cycle is pending, and where the scan starts.
  int m_holder = -1;
  int m_len    = 0;
  int m_start  = 0;
  int m_last   = 0;
  bit m_gap    = 1'b0;
  bit m_exp    = 1'b0;

  logic gv_prev = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .expired     (expired)
  );

  // One line per granted transaction.
  always @(negedge clk) begin
    if (grant_valid && !gv_prev)
      $display("grant id=%0d req=%h t=%0t", grant_id, req, $time);
    gv_prev <= grant_valid;
  end

  // Apply the behaviour of one clock edge to the model.
  task automatic model_edge(input logic [7:0] r, input logic rn);
    int w;
    if (!rn) begin
      m_holder = -1; m_len = 0; m_start = 0; m_gap = 1'b0; m_exp = 1'b0;
    end else if (m_holder >= 0) begin
      m_exp = 1'b0;
      if (!r[m_holder]) begin
        m_last = m_holder; m_holder = -1; m_gap = 1'b1;
      end else if (m_len == TB_MAX_HOLD) begin
        m_last = m_holder; m_holder = -1; m_gap = 1'b1; m_exp = 1'b1;
      end else begin
        m_len++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0; m_exp = 1'b0; m_start = (m_last + 1) % 8;
    end else begin
      m_exp = 1'b0;
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && r[(m_start + k) % 8]) w = (m_start + k) % 8;
      if (w >= 0) begin
        m_holder = w; m_len = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample #1 later.
  task automatic step(input logic [7:0] r, input logic rn);
    req = r;
    reset_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
  endtask

  function automatic logic [12:0] obs();
    return {grant_valid, (grant_valid ? grant_id : 3'd0), grant, expired};
  endfunction

  function automatic logic [12:0] exp_vec(input logic v, input int id, input logic x);
    logic [2:0] i3;
    logic [7:0] g;
    i3 = v ? 3'(id) : 3'd0;
    g  = v ? (8'd1 << i3) : 8'd0;
    return {v, i3, g, x};
  endfunction

  task automatic test_reset;
    step(8'hA5, 1'b0);
    step(8'hA5, 1'b0);
    checks++;
    if ({grant_valid, grant_id, grant, expired} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b id=%0d g=%h x=%b want all zero", grant_valid, grant_id, grant, expired);
    end
    step(8'h04, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b1, 2, 1'b0)) begin
      errors++; $display("FAIL single_req got=%h want=%h", obs(), exp_vec(1'b1, 2, 1'b0));
    end
    step(8'h04, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b1, 2, 1'b0)) begin
      errors++; $display("FAIL single_hold got=%h want=%h", obs(), exp_vec(1'b1, 2, 1'b0));
    end
    step(8'h00, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
      errors++; $display("FAIL single_release got=%h want=%h", obs(), exp_vec(1'b0, 0, 1'b0));
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_rotation;
    logic [7:0] drop;
    int e;
    step(8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      e = k % 8;
      for (int c = 0; c < 3; c++) begin
        step(8'hFF, 1'b1);
        checks++;
        if (obs() !== exp_vec(1'b1, e, 1'b0)) begin
          errors++; $display("FAIL rotation_grant k=%0d c=%0d got=%h want=%h", k, c, obs(), exp_vec(1'b1, e, 1'b0));
        end
      end
      drop = 8'hFF & ~(8'd1 << e);
      step(drop, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
        errors++; $display("FAIL rotation_gap k=%0d got=%h want=%h", k, obs(), exp_vec(1'b0, 0, 1'b0));
      end
      step(8'hFF, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
        errors++; $display("FAIL rotation_idle k=%0d got=%h want=%h", k, obs(), exp_vec(1'b0, 0, 1'b0));
      end
    end
  endtask

  task automatic test_timeout;
    int e;
    step(8'h00, 1'b0);
    for (int rnd = 0; rnd < 3; rnd++) begin
      e = (rnd == 1) ? 7 : 0;
      for (int c = 0; c < TB_MAX_HOLD; c++) begin
        step(8'h81, 1'b1);
        checks++;
        if (obs() !== exp_vec(1'b1, e, 1'b0)) begin
          errors++; $display("FAIL timeout_grant r=%0d c=%0d got=%h want=%h", rnd, c, obs(), exp_vec(1'b1, e, 1'b0));
        end
      end
      step(8'h81, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b1)) begin
        errors++; $display("FAIL timeout_expired r=%0d got=%h want=%h", rnd, obs(), exp_vec(1'b0, 0, 1'b1));
      end
      step(8'h81, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
        errors++; $display("FAIL timeout_idle r=%0d got=%h want=%h", rnd, obs(), exp_vec(1'b0, 0, 1'b0));
      end
    end
  endtask

  task automatic test_sole;
    step(8'h00, 1'b0);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int c = 0; c < TB_MAX_HOLD; c++) begin
        step(8'h20, 1'b1);
        checks++;
        if (obs() !== exp_vec(1'b1, 5, 1'b0)) begin
          errors++; $display("FAIL sole_grant r=%0d c=%0d got=%h want=%h", rnd, c, obs(), exp_vec(1'b1, 5, 1'b0));
        end
      end
      step(8'h20, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b1)) begin
        errors++; $display("FAIL sole_expired r=%0d got=%h want=%h", rnd, obs(), exp_vec(1'b0, 0, 1'b1));
      end
      step(8'h20, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
        errors++; $display("FAIL sole_idle r=%0d got=%h want=%h", rnd, obs(), exp_vec(1'b0, 0, 1'b0));
      end
    end
  endtask

  task automatic test_ignore;
    logic [7:0] r;
    step(8'h00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      r = {7'($urandom), 1'b1};
      step(r, 1'b1);
      checks++;
      if (obs() !== exp_vec(1'b1, 0, 1'b0)) begin
        errors++; $display("FAIL ignore_hold c=%0d req=%h got=%h want=%h", c, r, obs(), exp_vec(1'b1, 0, 1'b0));
      end
    end
    r = 8'($urandom) & 8'hFE;
    step(r, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
      errors++; $display("FAIL ignore_release got=%h want=%h", obs(), exp_vec(1'b0, 0, 1'b0));
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_reset_mid;
    step(8'h00, 1'b0);
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b1, 3, 1'b0)) begin
      errors++; $display("FAIL midreset_pre got=%h want=%h", obs(), exp_vec(1'b1, 3, 1'b0));
    end
    step(8'h08, 1'b0);
    checks++;
    if ({grant_valid, grant_id, grant, expired} !== 13'd0) begin
      errors++; $display("FAIL midreset_drop got v=%b id=%0d g=%h x=%b want all zero", grant_valid, grant_id, grant, expired);
    end
    step(8'hFF, 1'b1);
    checks++;
    if (obs() !== exp_vec(1'b1, 0, 1'b0)) begin
      errors++; $display("FAIL midreset_ptr got=%h want=%h", obs(), exp_vec(1'b1, 0, 1'b0));
    end
    // Reset landing exactly on the timeout edge must not pulse expired.
    for (int c = 1; c < TB_MAX_HOLD; c++) step(8'hFF, 1'b1);
    step(8'hFF, 1'b0);
    checks++;
    if (obs() !== exp_vec(1'b0, 0, 1'b0)) begin
      errors++; $display("FAIL midreset_at_limit got=%h want=%h", obs(), exp_vec(1'b0, 0, 1'b0));
    end
    step(8'h00, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] r;
    logic       rn;
    logic [12:0] want;
    r = 8'h00;
    step(8'h00, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0: r = 8'($urandom);
          1: r = 8'($urandom) & 8'($urandom);
          2: r = 8'd1 << $urandom_range(0, 7);
          default: r = 8'h00;
        endcase
      end
      rn = ($urandom_range(0, 299) != 0);
      step(r, rn);
      want = exp_vec(m_holder >= 0, (m_holder >= 0) ? m_holder : 0, m_exp);
      checks++;
      if (obs() !== want) begin
        errors++; $display("FAIL random n=%0d req=%h got=%h want=%h", n, r, obs(), want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_sole();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
